// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
//  - OP_* : operation codes on the op port (SLL, SRL, SRA, ROR)
//  - state_t : sequencer FSM states
//  - is_ready() : states in which a new start may be accepted
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_ready(input state_t st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between the EX-stage control and the shift sequencer.
//  start/op/shamt/din : request, driven by the master (EX control)
//  ready/busy/done/res : status and result, driven by the slave (sequencer)
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    modport master (
        output start, op, shamt, din,
        input  ready, busy, done, res
    );

    modport slave (
        input  start, op, shamt, din,
        output ready, busy, done, res
    );
endinterface

// File: rtl/shift_seq_ctrl_shift1_step.sv
// Combinational single-position shift step.
//  d      in  WIDTH  current data
//  op     in  2      operation code (OP_SLL/OP_SRL/OP_SRA/OP_ROR)
//  d_next out WIDTH  data after one 1-bit step
module shift1_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] d_next
);
    always_comb begin
        d_next = d;
        case (op)
            OP_SLL:  d_next = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  d_next = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  d_next = {d[WIDTH-1], d[WIDTH-1:1]};
            default: d_next = {d[0], d[WIDTH-1:1]};
        endcase
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle variable-amount shift sequencer. Shifts the latched operand by
// one position per clock for shamt cycles, then pulses done for one cycle.
//  clk  in  1   rising-edge clock
//  rst  in  1   asynchronous active-high reset
//  bus  slave   start/op/shamt/din request; ready/busy/done/res status
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    shift_seq_ctrl_if.slave  bus
);
    state_t           state, state_next;
    logic [SHW-1:0]   count, count_next;
    logic [WIDTH-1:0] data, data_next, step_out;
    logic [1:0]       op_reg, op_next;
    logic             accept;

    shift1_step #(.WIDTH(WIDTH)) u_step (
        .d      (data),
        .op     (op_reg),
        .d_next (step_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            data   <= '0;
            op_reg <= OP_SLL;
        end else begin
            state  <= state_next;
            count  <= count_next;
            data   <= data_next;
            op_reg <= op_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        data_next  = data;
        op_next    = op_reg;
        accept     = is_ready(state) && bus.start;

        case (state)
            ST_SHIFT: begin
                data_next  = step_out;
                count_next = count - SHW'(1);
                if (count == SHW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_IDLE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // A start in DONE overrides the return to IDLE, giving back-to-back issue.
        if (accept) begin
            data_next  = bus.din;
            op_next    = bus.op;
            count_next = bus.shamt;
            state_next = (bus.shamt == '0) ? ST_DONE : ST_SHIFT;
        end
    end

    assign bus.ready = is_ready(state);
    assign bus.busy  = (state == ST_SHIFT);
    assign bus.done  = (state == ST_DONE);
    assign bus.res   = data;
endmodule
